// File: rtl/audio_pkg.sv
// Shared types and clip table for the audio clip player.
package audio_pkg;

  typedef enum logic [1:0] {SND_NONE, SND_JUMP, SND_DEAD, SND_WIN} snd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_LATCH, ST_WAIT} play_state_t;

  // Start address of each clip in the sound ROM.
  function automatic int unsigned clip_base(input snd_t clip);
    case (clip)
      SND_JUMP: clip_base = 32'h0000;
      SND_DEAD: clip_base = 32'h1000;
      SND_WIN:  clip_base = 32'h3000;
      default:  clip_base = 32'h0000;
    endcase
  endfunction

  // Number of samples in each clip.
  function automatic int unsigned clip_len(input snd_t clip);
    case (clip)
      SND_JUMP: clip_len = 32'h1000;
      SND_DEAD: clip_len = 32'h2000;
      SND_WIN:  clip_len = 32'h4000;
      default:  clip_len = 32'h0001;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Output-sample-rate divider: counts 0..CLK_DIV-1 and flags the last count.
module sample_tick_gen #(
  parameter int CLK_DIV = 1042
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic wrap
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign wrap = (div_cnt == CW'(CLK_DIV - 1));

  // Free-running divider; clear realigns the phase to a new trigger.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
    end else if (wrap) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_clip_player.sv
// Plays one stored PCM clip per new audio_select code, one sample per CLK_DIV cycles.
//
// state | meaning
// IDLE  | no clip playing, outputs quiet
// FETCH | rom_addr was just registered; waiting for ROM read latency
// LATCH | rom_data valid; capture sample and strobe sample_valid
// WAIT  | hold sample until the divider wraps, then next sample or finish
module audio_clip_player
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 1042,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        audio_select,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic [1:0]        playing_clip,
  output logic              clip_done
);

  play_state_t       state, state_d;
  snd_t              clip, clip_d;
  logic [1:0]        prev_sel;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] sample_d;
  logic              valid_d, done_d, busy_d;
  logic [1:0]        playing_d;
  logic              trigger;
  logic              wrap;

  // A held code fires once; returning to 00 re-arms the same code.
  assign trigger = (audio_select != 2'b00) && (audio_select != prev_sel);

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (trigger),
    .wrap  (wrap)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      clip         <= SND_NONE;
      prev_sel     <= 2'b00;
      idx          <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip_done    <= 1'b0;
      busy         <= 1'b0;
      playing_clip <= 2'b00;
    end else begin
      state        <= state_d;
      clip         <= clip_d;
      prev_sel     <= audio_select;
      idx          <= idx_d;
      rom_addr     <= addr_d;
      sample_out   <= sample_d;
      sample_valid <= valid_d;
      clip_done    <= done_d;
      busy         <= busy_d;
      playing_clip <= playing_d;
    end
  end

  // Next-state logic; a trigger overrides whatever the FSM was doing.
  always_comb begin
    state_d   = state;
    clip_d    = clip;
    idx_d     = idx;
    addr_d    = rom_addr;
    sample_d  = sample_out;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy;
    playing_d = playing_clip;

    if (trigger) begin
      clip_d    = snd_t'(audio_select);
      idx_d     = '0;
      addr_d    = ADDR_W'(clip_base(snd_t'(audio_select)));
      state_d   = ST_FETCH;
      busy_d    = 1'b1;
      playing_d = audio_select;
    end else begin
      case (state)
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: begin
          sample_d = rom_data;
          valid_d  = 1'b1;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          if (wrap) begin
            if (idx == ADDR_W'(clip_len(clip) - 1)) begin
              done_d    = 1'b1;
              busy_d    = 1'b0;
              playing_d = 2'b00;
              sample_d  = '0;
              state_d   = ST_IDLE;
            end else begin
              idx_d   = idx + 1'b1;
              addr_d  = ADDR_W'(clip_base(clip)) + idx + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_clip_player.sv
// Directed bench for audio_clip_player with CLK_DIV=4 and a ROM returning its address.
module tb_audio_clip_player;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    audio_select;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          busy;
  logic [1:0]    playing_clip;
  logic          clip_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data equals address, one cycle of latency.
  always_ff @(posedge clk) rom_data <= rom_addr;

  audio_clip_player #(.CLK_DIV(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_select (audio_select),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .playing_clip (playing_clip),
    .clip_done    (clip_done)
  );

  task automatic test_reset();
    reset = 1'b1;
    audio_select = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, sample_valid, clip_done, playing_clip, rom_addr, sample_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b clip=%b addr=%h sample=%h required all 0",
               busy, sample_valid, clip_done, playing_clip, rom_addr, sample_out);
    end
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, sample_valid, clip_done, rom_addr, sample_out} !== '0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d busy=%b valid=%b done=%b addr=%h sample=%h required all 0",
                 c, busy, sample_valid, clip_done, rom_addr, sample_out);
      end
    end
  endtask

  task automatic test_full_jump();
    int n = 0;
    int done_seen = 0;
    audio_select = 2'b01;
    @(posedge clk);
    @(negedge clk);
    audio_select = 2'b00;
    checks++;
    if (busy !== 1'b1 || playing_clip !== 2'b01) begin
      errors++;
      $display("FAIL jump_start: busy=%b clip=%b required 1/01", busy, playing_clip);
    end
    for (int c = 1; c <= 17000 && done_seen == 0; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        checks++;
        if (c !== 2 + 4 * n || sample_out !== DW'(n)) begin
          errors++;
          $display("FAIL jump_sample: cycle %0d sample=%h required cycle %0d sample=%h",
                   c, sample_out, 2 + 4 * n, n);
        end
        n++;
      end
      if (clip_done) begin
        done_seen = 1;
        checks++;
        if (c !== 16384 || busy !== 1'b0 || sample_out !== '0 || playing_clip !== 2'b00) begin
          errors++;
          $display("FAIL jump_end: cycle %0d busy=%b sample=%h clip=%b required cycle 16384 0/0000/00",
                   c, busy, sample_out, playing_clip);
        end
      end
    end
    checks++;
    if (done_seen !== 1 || n !== 4096) begin
      errors++;
      $display("FAIL jump_count: done_seen=%0d samples=%0d required 1 and 4096", done_seen, n);
    end
    @(negedge clk);
    checks++;
    if (clip_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL jump_done_pulse: done=%b busy=%b required 0/0 after pulse", clip_done, busy);
    end
  endtask

  task automatic test_held_win();
    int n = 0;
    audio_select = 2'b11;
    @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (playing_clip !== 2'b11 || busy !== 1'b1) begin
        errors++;
        $display("FAIL win_playing: cycle %0d clip=%b busy=%b required 11/1", c, playing_clip, busy);
      end
      if (sample_valid) begin
        checks++;
        if (c !== 2 + 4 * n || sample_out !== DW'(16'h3000 + n)) begin
          errors++;
          $display("FAIL win_sample: cycle %0d sample=%h required cycle %0d sample=%h",
                   c, sample_out, 2 + 4 * n, 16'h3000 + n);
        end
        n++;
      end
    end
    checks++;
    if (n !== 12) begin
      errors++;
      $display("FAIL win_count: strobes=%0d required 12", n);
    end
  endtask

  task automatic test_restart();
    int n = 0;
    audio_select = 2'b01;
    @(posedge clk);
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if (clip_done !== 1'b0) begin
        errors++;
        $display("FAIL restart_no_done: cycle %0d done=%b required 0", c, clip_done);
      end
      if (c <= 22 && sample_valid) begin
        checks++;
        if (sample_out !== DW'(n)) begin
          errors++;
          $display("FAIL restart_jump_sample: cycle %0d sample=%h required %h", c, sample_out, n);
        end
        n++;
      end
      if (c == 22) audio_select = 2'b10;
      if (c == 23) begin
        checks++;
        if (playing_clip !== 2'b10 || busy !== 1'b1 || rom_addr !== 16'h1000) begin
          errors++;
          $display("FAIL restart_switch: clip=%b busy=%b addr=%h required 10/1/1000",
                   playing_clip, busy, rom_addr);
        end
      end
      if (c == 24 || c == 26) begin
        checks++;
        if (sample_valid !== 1'b0) begin
          errors++;
          $display("FAIL restart_gap: cycle %0d valid=%b required 0", c, sample_valid);
        end
      end
      if (c == 25) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'h1000) begin
          errors++;
          $display("FAIL restart_first: valid=%b sample=%h required 1/1000", sample_valid, sample_out);
        end
      end
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL restart_idx: jump strobes=%0d required 6", n);
    end
  endtask

  task automatic test_back_to_back();
    audio_select = 2'b00;
    @(negedge clk);
    audio_select = 2'b10;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rom_addr !== 16'h1000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: addr=%h busy=%b required 1000/1", rom_addr, busy);
    end
    audio_select = 2'b00;
    @(negedge clk);
    audio_select = 2'b10;
    @(negedge clk);
    audio_select = 2'b00;
    checks++;
    if (sample_valid !== 1'b0 || rom_addr !== 16'h1000) begin
      errors++;
      $display("FAIL b2b_second: valid=%b addr=%h required 0/1000", sample_valid, rom_addr);
    end
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (c == 4 || c == 8) begin
        if (sample_valid !== 1'b1 || sample_out !== DW'(16'h1000 + (c - 4) / 4)) begin
          errors++;
          $display("FAIL b2b_sample: cycle %0d valid=%b sample=%h required 1/%h",
                   c, sample_valid, sample_out, 16'h1000 + (c - 4) / 4);
        end
      end else if (sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap: cycle %0d valid=%b required 0", c, sample_valid);
      end
    end
  endtask

  task automatic test_reset_mid_clip();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, sample_valid, clip_done, playing_clip, rom_addr, sample_out} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b valid=%b done=%b clip=%b addr=%h sample=%h required all 0",
               busy, sample_valid, clip_done, playing_clip, rom_addr, sample_out);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (clip_done !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet: cycle %0d done=%b valid=%b busy=%b required 0",
                 c, clip_done, sample_valid, busy);
      end
    end
    audio_select = 2'b11;
    @(posedge clk);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2 || c == 6) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== DW'(16'h3000 + (c - 2) / 4) ||
            playing_clip !== 2'b11) begin
          errors++;
          $display("FAIL midreset_replay: cycle %0d valid=%b sample=%h clip=%b required 1/%h/11",
                   c, sample_valid, sample_out, playing_clip, 16'h3000 + (c - 2) / 4);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    audio_select = 2'b00;
    test_reset();
    test_full_jump();
    test_held_win();
    test_restart();
    test_back_to_back();
    test_reset_mid_clip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
